icache_sa: RTL and testbench
============================

ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 The block SHALL have the parameter WAYS, default 2, meaning associativity (power of two, 1..8).
REQ-002 The block SHALL have the parameter SETS, default 16, meaning number of sets (power of two, at least 2).
REQ-003 The block SHALL have the parameter LINE_WORDS, default 4, meaning 32-bit words per line (power of two, 1..16).
REQ-004 The block SHALL have the port clk  input  1  meaning the single clock, rising-edge active.
REQ-005 The block SHALL have the port rst  input  1  meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have the port rdy  input  1  meaning global enable; low freezes all state.
REQ-007 The block SHALL have the port req_valid  input  1  meaning the fetch request is valid.
REQ-008 The block SHALL have the port req_addr  input  32  meaning the fetch byte address, with bits [1:0] ignored.
REQ-009 The block SHALL have the port req_ready  output  1  meaning the block can accept a fetch request this cycle.
REQ-010 The block SHALL have the port resp_valid  output  1  meaning a one-cycle pulse that resp_inst is valid.
REQ-011 The block SHALL have the port resp_inst  output  32  meaning the instruction word.
REQ-012 The block SHALL have the port clear  input  1  meaning mispredict squash: drop the pending response.
REQ-013 The block SHALL have the port flush  input  1  meaning fence.i: invalidate all lines.
REQ-014 The block SHALL have the port mem_req_valid  output  1  meaning a line-refill request is pending.
REQ-015 The block SHALL have the port mem_req_addr  output  32  meaning the line-aligned refill address.
REQ-016 The block SHALL have the port mem_req_ready  input  1  meaning memory accepts the refill request.
REQ-017 The block SHALL have the port mem_resp_valid  input  1  meaning one refill beat is valid.
REQ-018 The block SHALL have the port mem_resp_data  input  32  meaning the refill word; beats arrive in ascending word order.

Function
REQ-019 The address split SHALL be: word offset [log2(LINE_WORDS)+1:2], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-020 Per set and way, the block SHALL store a valid bit, a tag and LINE_WORDS data words; per set it SHALL store a round-robin victim pointer of width log2(WAYS).
REQ-021 The FSM states SHALL be IDLE, LOOKUP, MISS_REQ, REFILL and RESPOND.
REQ-022 req_ready SHALL be 1 only in IDLE with rdy=1 and flush=0; a request is accepted when req_valid&req_ready, and its address is latched.
REQ-023 LOOKUP SHALL compare all ways in parallel; on a hit, resp_valid=1 with the hit word in that same cycle (2 cycles after acceptance), and the FSM SHALL return to IDLE.
REQ-024 A lookup miss SHALL move the FSM to MISS_REQ, which drives mem_req_valid=1 with mem_req_addr = {tag,index,zero offset} until mem_req_ready=1, then moves to REFILL.
REQ-025 REFILL SHALL write each mem_resp_valid beat into the victim way at the incrementing word counter; after beat LINE_WORDS-1 it SHALL set the way valid, write the tag, advance the set's victim pointer modulo WAYS (wrapping to 0), and go to RESPOND.
REQ-026 If any way in a set is invalid, the lowest-numbered invalid way SHALL be the victim in preference to the pointer.
REQ-027 RESPOND SHALL drive resp_valid=1 with the requested word for one cycle, then return to IDLE.
REQ-028 A clear in LOOKUP SHALL suppress the response and return the FSM to IDLE.
REQ-029 A clear in MISS_REQ or REFILL SHALL NOT abort the memory transaction; the line SHALL still be installed, and the RESPOND pulse SHALL be suppressed.
REQ-030 A clear coincident with resp_valid SHALL suppress resp_valid.
REQ-031 flush SHALL clear every valid bit and every victim pointer at the next edge, in any state.
REQ-032 A flush during MISS_REQ or REFILL SHALL leave the refilled line invalid, while the response is still delivered unless clear is also asserted.
REQ-033 flush and clear SHALL be independent, and both SHALL apply when asserted together.
REQ-034 With rdy=0, no state SHALL change, req_ready SHALL be 0, outputs SHALL hold, and mem_resp beats arriving while rdy=0 are not required to be captured (memory is stalled by the same rdy).
REQ-035 resp_inst SHALL be don't-care when resp_valid=0.

Reset
REQ-036 On rst=0, asynchronously: FSM=IDLE; all valid bits and victim pointers 0; the beat counter 0; resp_valid=0, mem_req_valid=0, req_ready=0, resp_inst=0, mem_req_addr=0.
REQ-037 Tag and data arrays SHALL need no reset.
REQ-038 Reset asserted mid-refill SHALL abandon the refill and leave no line valid.
REQ-039 After rst rises, req_ready SHALL be 1 in the first cycle with rdy=1.

Verification (WAYS=2, SETS=16, LINE_WORDS=4)
REQ-040 Cold miss: request 0x00000104 with memory returning beats 0xA0..0xA3 -> one mem_req at 0x00000100, then resp_inst=0xA1 on the cycle after the last beat; a repeat request 0x0000010C -> a hit, resp_inst=0xA3, 2 cycles after acceptance, with no mem_req.
REQ-041 Associativity/replacement: fill 0x100, 0x1100 and 0x2100 (same set 0) -> 0x2100 evicts way 0 (0x100); a subsequent 0x1100 hits and 0x100 misses.
REQ-042 Squash: clear asserted during REFILL beat 2 -> all 4 beats are consumed, no resp_valid is produced, and the next request to the same line hits.
REQ-043 fence.i: flush after the lines are valid -> the next request to 0x104 misses; a flush during REFILL -> the response is delivered but a re-request misses.
REQ-044 Stall/reset: rdy=0 for 3 cycles during MISS_REQ -> mem_req_valid holds and no state advances; rst=0 in REFILL -> all outputs go to 0 immediately and a following request to that line misses.

Source files
------------

// File: rtl/icache_sa.sv
// Set-associative instruction cache with round-robin replacement and line refill.
// Handles one fetch at a time; clear squashes the pending response, flush invalidates all lines.
module icache_sa #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    input  logic        clear,
    input  logic        flush,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int unsigned OW = $clog2(LINE_WORDS);
    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned TW = 30 - OW - IW;
    localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned CW = (OW > 0) ? OW : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND} state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [WW-1:0]     victim_q, victim_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              squash_q, squash_d;
    logic              flushed_q, flushed_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_inst_q, resp_inst_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [31:0]       mem_req_addr_q, mem_req_addr_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WW-1:0]     ptr_q   [SETS];
    logic [TW-1:0]     tag_q   [SETS][WAYS];
    logic [31:0]       data_q  [SETS][WAYS][LINE_WORDS];

    logic [CW-1:0]     off;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     tag;
    logic              hit, inv_found, wr_en, fill_done;
    logic [WW-1:0]     hit_way, inv_way;
    logic [31:0]       hit_word;

    assign off = CW'((addr_q >> 2) & 32'(LINE_WORDS - 1));
    assign idx = IW'(addr_q >> (2 + OW));
    assign tag = TW'(addr_q >> (2 + OW + IW));

    assign req_ready     = rst && (state_q == IDLE) && rdy && !flush;
    assign resp_valid    = resp_valid_q && !clear;
    assign resp_inst     = resp_inst_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;

    // Parallel tag compare plus lowest-numbered invalid way for victim preference
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
    end

    assign hit_word = data_q[idx][hit_way][off];

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        victim_d        = victim_q;
        cnt_d           = cnt_q;
        squash_d        = squash_q;
        flushed_d       = flushed_q;
        resp_valid_d    = 1'b0;
        resp_inst_d     = resp_inst_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        wr_en           = 1'b0;
        fill_done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d    = req_addr & ~32'h3;
                    squash_d  = 1'b0;
                    flushed_d = 1'b0;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_inst_d  = hit_word;
                    state_d      = IDLE;
                end else begin
                    victim_d        = inv_found ? inv_way : ptr_q[idx];
                    cnt_d           = '0;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = addr_q & ~32'(LINE_WORDS * 4 - 1);
                    state_d         = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (clear) squash_d = 1'b1;
                if (flush) flushed_d = 1'b1;
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = REFILL;
                end
            end
            REFILL: begin
                if (clear) squash_d = 1'b1;
                if (flush) flushed_d = 1'b1;
                if (mem_resp_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == off) resp_inst_d = mem_resp_data;
                    if (cnt_q == CW'(LINE_WORDS - 1)) begin
                        fill_done    = 1'b1;
                        resp_valid_d = !(squash_q || clear);
                        state_d      = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control, valid bits and victim pointers; everything freezes while rdy is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            victim_q        <= '0;
            cnt_q           <= '0;
            squash_q        <= 1'b0;
            flushed_q       <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_inst_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            valid_q         <= '{default: '0};
            ptr_q           <= '{default: '0};
        end else if (rdy) begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            victim_q        <= victim_d;
            cnt_q           <= cnt_d;
            squash_q        <= squash_d;
            flushed_q       <= flushed_d;
            resp_valid_q    <= resp_valid_d;
            resp_inst_q     <= resp_inst_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            if (flush) begin
                valid_q <= '{default: '0};
                ptr_q   <= '{default: '0};
            end else if (fill_done && !flushed_q) begin
                valid_q[idx][victim_q] <= 1'b1;
                ptr_q[idx] <= (ptr_q[idx] == WW'(WAYS - 1)) ? '0 : ptr_q[idx] + WW'(1);
            end
        end
    end

    // Tag and data storage carry no reset; validity is tracked separately
    always_ff @(posedge clk) begin
        if (rdy && wr_en) data_q[idx][victim_q][cnt_q] <= mem_resp_data;
        if (rdy && fill_done) tag_q[idx][victim_q] <= tag;
    end

endmodule

// File: tb/tb_icache_sa.sv
// Randomized bench for icache_sa against a set/way/pointer reference model.
// The bench plays the memory side and walks each fetch cycle by cycle.
module tb_icache_sa;

    localparam int WAYS_M = 2;
    localparam int SETS_M = 16;
    localparam int LW_M   = 4;

    logic        clk = 1'b0;
    logic        rst, rdy, req_valid, clear, flush;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] req_addr, mem_resp_data;
    logic        req_ready, resp_valid, mem_req_valid;
    logic [31:0] resp_inst, mem_req_addr;

    icache_sa #(.WAYS(WAYS_M), .SETS(SETS_M), .LINE_WORDS(LW_M)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_inst(resp_inst),
        .clear(clear), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          m_valid [SETS_M][WAYS_M];
    int unsigned m_tag   [SETS_M][WAYS_M];
    logic [31:0] m_data  [SETS_M][WAYS_M][LW_M];
    int          m_ptr   [SETS_M];

    bit          data_mode;
    logic [31:0] last_resp;
    int          o_clr_lookup, o_clr_beat, o_flush_beat, o_clr_resp, o_stall, o_rst_beat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] line, input int b);
        if (data_mode) return 32'hA0 + 32'(b);
        return (line * 32'h9E37_79B1) ^ {4'(b), 28'h0} ^ 32'h0000_1234;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS_M; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS_M; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic opts_none();
        o_clr_lookup = 0; o_clr_beat = -1; o_flush_beat = -1;
        o_clr_resp = 0; o_stall = 0; o_rst_beat = -1;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_noready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        model_clear();
    endtask

    // One fetch transaction end to end, checked against the model
    task automatic fetch(input logic [31:0] a, output bit saw_miss);
        int s, w, hw, vict, d, gap;
        int unsigned t;
        bit hit, squashed, flushed;
        logic [31:0] line;
        s = int'((a >> 4) % 32'(SETS_M));
        w = int'((a >> 2) % 32'(LW_M));
        t = a >> 8;
        line = a & 32'hFFFF_FFF0;
        hit = 1'b0; hw = 0;
        for (int i = 0; i < WAYS_M; i++)
            if (m_valid[s][i] && m_tag[s][i] == t) begin hit = 1'b1; hw = i; end
        vict = m_ptr[s];
        for (int i = WAYS_M - 1; i >= 0; i--) if (!m_valid[s][i]) vict = i;
        saw_miss = 1'b0;

        @(negedge clk);
        req_valid = 1'b1; req_addr = a;
        #1 chk("req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom;
        clear = 1'(o_clr_lookup);
        #1 chk("lookup_quiet", {30'b0, resp_valid, mem_req_valid}, 0);
        if (o_clr_lookup != 0) begin
            @(negedge clk);
            clear = 1'b0;
            #1 chk("clr_lookup_resp", {31'b0, resp_valid}, 0);
            chk("clr_lookup_memreq", mem_req_valid, 0);
            chk("clr_lookup_idle", req_ready, 1);
            return;
        end
        @(negedge clk);
        clear = hit && (o_clr_resp != 0);
        #1 saw_miss = mem_req_valid;
        if (hit) begin
            chk("hit_valid", resp_valid, (o_clr_resp != 0) ? 0 : 1);
            chk("hit_no_memreq", mem_req_valid, 0);
            if (o_clr_resp == 0) begin
                chk("hit_inst", resp_inst, m_data[s][hw][w]);
                last_resp = resp_inst;
            end
            clear = 1'b0;
            return;
        end
        chk("miss_req", mem_req_valid, 1);
        chk("miss_addr", mem_req_addr, line);
        chk("miss_no_resp", resp_valid, 0);
        squashed = 1'b0; flushed = 1'b0;

        if (o_stall != 0) begin
            rdy = 1'b0; mem_req_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                #1 chk("stall_memreq", mem_req_valid, 1);
                chk("stall_addr", mem_req_addr, line);
                chk("stall_noready", req_ready, 0);
            end
            rdy = 1'b1; mem_req_ready = 1'b0;
        end
        d = int'($urandom_range(2, 0));
        for (int k = 0; k < d; k++) begin
            @(negedge clk);
            #1 chk("memreq_hold", mem_req_valid, 1);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1 chk("memreq_drop", mem_req_valid, 0);

        for (int b = 0; b < LW_M; b++) begin
            gap = int'($urandom_range(1, 0));
            for (int k = 0; k < gap; k++) begin
                @(negedge clk);
                #1 chk("gap_quiet", resp_valid, 0);
            end
            mem_resp_valid = 1'b1;
            mem_resp_data = memval(line, b);
            if (b == o_rst_beat) begin
                rst = 1'b0;
                #1 chk("rst_outputs", {resp_valid, mem_req_valid, req_ready, |resp_inst, |mem_req_addr}, 0);
                mem_resp_valid = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                model_clear();
                #1 chk("rst_ready", req_ready, 1);
                return;
            end
            clear = (b == o_clr_beat);
            flush = (b == o_flush_beat);
            if (clear) squashed = 1'b1;
            if (flush) flushed = 1'b1;
            @(negedge clk);
            if (flush) model_clear();
            mem_resp_valid = 1'b0; clear = 1'b0; flush = 1'b0;
            if (b < LW_M - 1) begin
                #1 chk("refill_quiet", resp_valid, 0);
            end
        end

        clear = 1'(o_clr_resp);
        #1 chk("fill_valid", resp_valid, (squashed || o_clr_resp != 0) ? 0 : 1);
        if (!squashed && o_clr_resp == 0) begin
            chk("fill_inst", resp_inst, memval(line, w));
            last_resp = resp_inst;
        end
        if (!flushed) begin
            m_valid[s][vict] = 1'b1;
            m_tag[s][vict] = t;
            for (int i = 0; i < LW_M; i++) m_data[s][vict][i] = memval(line, i);
            m_ptr[s] = (m_ptr[s] + 1) % WAYS_M;
        end
        @(negedge clk);
        clear = 1'b0;
        #1 chk("back_idle", req_ready, 1);
        chk("back_quiet", resp_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        int unsigned tags [4] = '{32'h0, 32'h1, 32'h2, 32'hABCDE};
        logic [31:0] a;
        rst = 1'b0; rdy = 1'b1; req_valid = 1'b0; req_addr = '0;
        clear = 1'b0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        data_mode = 1'b1; last_resp = '0;
        model_clear();
        opts_none();

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk("reset_outputs", {resp_valid, mem_req_valid, req_ready, |resp_inst, |mem_req_addr}, 0);
        rst = 1'b1;
        #1 chk("reset_ready", req_ready, 1);

        // Cold miss then hit on the same line
        fetch(32'h0000_0104, m); chk("cold_miss", m, 1); chk("cold_inst", last_resp, 32'hA1);
        fetch(32'h0000_010C, m); chk("warm_hit", m, 0);  chk("warm_inst", last_resp, 32'hA3);

        // Replacement within set 0
        data_mode = 1'b0;
        fetch(32'h0000_1100, m); chk("fill_1100", m, 1);
        fetch(32'h0000_2100, m); chk("fill_2100", m, 1);
        fetch(32'h0000_1100, m); chk("keep_1100", m, 0);
        fetch(32'h0000_0100, m); chk("evicted_0100", m, 1);

        // Squash during refill still installs the line
        o_clr_beat = 2;
        fetch(32'h0000_0354, m); chk("squash_miss", m, 1);
        opts_none();
        fetch(32'h0000_0350, m); chk("squash_then_hit", m, 0);

        // fence.i idle and mid-refill
        do_flush();
        fetch(32'h0000_0104, m); chk("flush_miss", m, 1);
        o_flush_beat = 1;
        fetch(32'h0000_0408, m); chk("flush_refill_miss", m, 1);
        opts_none();
        fetch(32'h0000_0408, m); chk("flush_refill_remiss", m, 1);

        // Stall in MISS_REQ, then reset mid-refill
        o_stall = 1;
        fetch(32'h0000_0508, m); chk("stall_miss", m, 1);
        opts_none();
        o_rst_beat = 2;
        fetch(32'h0000_0608, m);
        opts_none();
        fetch(32'h0000_0608, m); chk("post_rst_miss", m, 1);

        // Clear coincident with a hit response, and clear in LOOKUP
        o_clr_resp = 1;
        fetch(32'h0000_0604, m); chk("clr_resp_hit", m, 0);
        opts_none();
        o_clr_lookup = 1;
        fetch(32'h0000_0604, m);
        opts_none();

        for (int n = 0; n < 250; n++) begin
            opts_none();
            if ($urandom_range(24, 0) == 0) do_flush();
            o_clr_lookup = ($urandom_range(19, 0) == 0) ? 1 : 0;
            o_clr_beat   = ($urandom_range(9, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            o_flush_beat = ($urandom_range(14, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            o_clr_resp   = ($urandom_range(11, 0) == 0) ? 1 : 0;
            o_stall      = ($urandom_range(9, 0) == 0) ? 1 : 0;
            o_rst_beat   = ($urandom_range(39, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            a = (32'(tags[$urandom_range(3, 0)]) << 8) | (32'($urandom_range(2, 0)) << 4)
                | 32'($urandom_range(15, 0));
            fetch(a, m);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
